wake_filter: RTL and testbench

WAKE_FILTER -- requirements
Module: wake_filter

---
 rtl/wake_filter.sv | 109 ++++++++++
 tb/tb_wake_filter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wake_filter.sv
// Wake-pin conditioning: 2-flop sync + per-channel debounce, sticky rising-edge
// capture into wake_status, and a small IDLE/ARMED/TRIGGERED wake-request FSM.
module wake_filter #(
  parameter int NUM_WAKE = 5,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_WAKE-1:0] wake_raw,
  input  logic [CNT_W-1:0]    filter_delay,
  input  logic [NUM_WAKE-1:0] wake_mask,
  input  logic                arm,
  input  logic [NUM_WAKE-1:0] wake_clear,
  output logic [NUM_WAKE-1:0] wake_sources,
  output logic [NUM_WAKE-1:0] wake_status,
  output logic                wake_req,
  output logic [1:0]          fsm_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2
  } state_e;

  logic [NUM_WAKE-1:0] s1_q, s2_q;
  logic [NUM_WAKE-1:0] filt_q, filt_d;
  logic [CNT_W-1:0]    cnt_q [NUM_WAKE];
  logic [CNT_W-1:0]    cnt_d [NUM_WAKE];
  logic [NUM_WAKE-1:0] status_q, status_d;
  logic [NUM_WAKE-1:0] rise, set;
  state_e              state_q;
  logic                req_q;

  // Debounce: the level flips on the first mismatch cycle whose count has
  // reached the delay, so a lowered delay takes effect immediately.
  always_comb begin
    for (int i = 0; i < NUM_WAKE; i++) begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      filt_d[i] = filt_q[i];
      cnt_d[i]  = '0;
      if (s2_q[i] != filt_q[i]) begin
        if (cnt_q[i] >= filter_delay) filt_d[i] = s2_q[i];
        else                          cnt_d[i]  = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Capture happens on the same edge the filtered level rises; set beats clear.
  always_comb begin
    rise     = filt_d & ~filt_q;
    set      = (state_q == ARMED || state_q == TRIGGERED) ? (rise & wake_mask) : '0;
    status_d = (status_q & ~wake_clear) | set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      filt_q   <= '0;
      status_q <= '0;
      state_q  <= IDLE;
      req_q    <= 1'b0;
      for (int i = 0; i < NUM_WAKE; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: all sequential state uses non-blocking assignment so every flop samples pre-edge values.
      s1_q     <= wake_raw;
      s2_q     <= s1_q;
      filt_q   <= filt_d;
      status_q <= status_d;
      for (int i = 0; i < NUM_WAKE; i++) cnt_q[i] <= cnt_d[i];

      // wake_req is loaded alongside the state so it never depends on inputs combinationally.
      case (state_q)
        IDLE: begin
          if (arm) begin
            state_q <= ARMED;
            req_q   <= 1'b0;
          end
        end
        ARMED: begin
          if (|set) begin
            state_q <= TRIGGERED;
            req_q   <= 1'b1;
          end else if (!arm) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        TRIGGERED: begin
          if (status_d == '0) begin
            state_q <= arm ? ARMED : IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign wake_sources = filt_q;
  assign wake_status  = status_q;
  assign wake_req     = req_q;
  assign fsm_state    = state_q;

endmodule

// File: tb/tb_wake_filter.sv
// Directed bench for wake_filter: stimulus pushes hand-computed expectations
// tagged with a target cycle; a negedge monitor pops and compares them.
module tb_wake_filter;

  localparam int NW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NW-1:0] wake_raw;
  logic [CW-1:0] filter_delay;
  logic [NW-1:0] wake_mask;
  logic          arm;
  logic [NW-1:0] wake_clear;
  logic [NW-1:0] wake_sources;
  logic [NW-1:0] wake_status;
  logic          wake_req;
  logic [1:0]    fsm_state;

  wake_filter #(.NUM_WAKE(NW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .wake_raw     (wake_raw),
    .filter_delay (filter_delay),
    .wake_mask    (wake_mask),
    .arm          (arm),
    .wake_clear   (wake_clear),
    .wake_sources (wake_sources),
    .wake_status  (wake_status),
    .wake_req     (wake_req),
    .fsm_state    (fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            at_cyc;
    string         name;
    logic [NW-1:0] src;
    logic [NW-1:0] st;
    logic [1:0]    fsm;
    logic          req;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got src=%h st=%h fsm=%0d req=%b, expected src=%h st=%h fsm=%0d req=%b",
               name, act[12:8], act[7:3], act[2:1], act[0], req[12:8], req[7:3], req[2:1], req[0]);
    end
  endtask

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].at_cyc <= cyc) begin
        check(sb[i].name, {wake_sources, wake_status, fsm_state, wake_req},
              (sb[i].at_cyc == cyc) ? {sb[i].src, sb[i].st, sb[i].fsm, sb[i].req} : 13'bx);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic expect_at(input int n, input string name, input logic [NW-1:0] src,
                           input logic [NW-1:0] st, input logic [1:0] fsm, input logic req);
    exp_t e;
    e.at_cyc = cyc + n;
    e.name   = name;
    e.src    = src;
    e.st     = st;
    e.fsm    = fsm;
    e.req    = req;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; wake_raw = '0; filter_delay = 4'd3; wake_mask = '0; arm = 1'b0; wake_clear = '0;
    tick(2);
    expect_at(1, "reset", 5'h00, 5'h00, 2'd0, 1'b0);
    tick(1);
    rst = 1'b0; arm = 1'b1; wake_mask = 5'h1F;
    expect_at(1, "armed", 5'h00, 5'h00, 2'd1, 1'b0);
    tick(1);

    // Single channel, D=3: exactly 6 edges to the filtered rise.
    wake_raw = 5'h01;
    expect_at(5, "ch0_lat_minus1", 5'h00, 5'h00, 2'd1, 1'b0);
    expect_at(6, "ch0_rise",       5'h01, 5'h01, 2'd2, 1'b1);
    tick(6);
    wake_clear = 5'h01;
    expect_at(1, "clr_arm", 5'h01, 5'h00, 2'd1, 1'b0);
    tick(1);
    wake_clear = '0;

    wake_raw = 5'h00;
    expect_at(6, "ch0_fall", 5'h00, 5'h00, 2'd1, 1'b0);
    tick(6);
    wake_raw = 5'h01;
    expect_at(6, "ch0_rise2", 5'h01, 5'h01, 2'd2, 1'b1);
    tick(6);
    wake_clear = 5'h01; arm = 1'b0;
    expect_at(1, "clr_idle", 5'h01, 5'h00, 2'd0, 1'b0);
    tick(1);
    wake_clear = '0; arm = 1'b1;
    expect_at(1, "rearm", 5'h01, 5'h00, 2'd1, 1'b0);
    tick(1);

    // 3-cycle glitch on channel 2 must be rejected.
    wake_raw = 5'h05;
    expect_at(6,  "glitch_mid",  5'h01, 5'h00, 2'd1, 1'b0);
    expect_at(10, "glitch_done", 5'h01, 5'h00, 2'd1, 1'b0);
    tick(3);
    wake_raw = 5'h01;
    tick(7);

    // Mask selects which simultaneous rise is captured.
    wake_raw = 5'h00; wake_mask = 5'h02;
    expect_at(6, "all_low", 5'h00, 5'h00, 2'd1, 1'b0);
    tick(6);
    wake_raw = 5'h03;
    expect_at(6, "mask_sel", 5'h03, 5'h02, 2'd2, 1'b1);
    tick(6);

    // Set coinciding with clear on bit 3: set wins.
    wake_mask = 5'h0A; wake_raw = 5'h0B;
    expect_at(6, "set_wins", 5'h0B, 5'h0A, 2'd2, 1'b1);
    tick(5);
    wake_clear = 5'h08;
    tick(1);
    wake_clear = '0;
    expect_at(1, "set_hold", 5'h0B, 5'h0A, 2'd2, 1'b1);
    tick(1);

    wake_clear = 5'h1F;
    expect_at(1, "clr_all", 5'h0B, 5'h00, 2'd1, 1'b0);
    tick(1);
    wake_clear = '0; wake_mask = 5'h1F;
    wake_raw = 5'h1F;
    expect_at(6, "multi", 5'h1F, 5'h14, 2'd2, 1'b1);
    tick(6);

    // Lowering the delay below the running count flips on the next mismatch.
    wake_raw = 5'h0F;
    expect_at(4, "dly_pre",   5'h1F, 5'h14, 2'd2, 1'b1);
    expect_at(5, "dly_lower", 5'h0F, 5'h14, 2'd2, 1'b1);
    tick(4);
    filter_delay = 4'd1;
    tick(1);
    filter_delay = 4'd0;
    wake_raw = 5'h1F;
    expect_at(2, "d0_pre",  5'h0F, 5'h14, 2'd2, 1'b1);
    expect_at(3, "d0_rise", 5'h1F, 5'h14, 2'd2, 1'b1);
    tick(3);
    filter_delay = 4'd3;

    // IDLE: filtering continues but nothing is captured.
    wake_clear = 5'h1F; arm = 1'b0;
    expect_at(1, "to_idle", 5'h1F, 5'h00, 2'd0, 1'b0);
    tick(1);
    wake_clear = '0;
    wake_raw = 5'h1E;
    expect_at(6, "idle_fall", 5'h1E, 5'h00, 2'd0, 1'b0);
    tick(6);
    wake_raw = 5'h1F;
    expect_at(6, "idle_nocap", 5'h1F, 5'h00, 2'd0, 1'b0);
    tick(6);

    // Reset pulse while TRIGGERED with pins held high.
    arm = 1'b1;
    expect_at(1, "arm2", 5'h1F, 5'h00, 2'd1, 1'b0);
    tick(1);
    wake_raw = 5'h1D;
    expect_at(6, "b1_low", 5'h1D, 5'h00, 2'd1, 1'b0);
    tick(6);
    wake_raw = 5'h1F;
    expect_at(6, "b1_rise", 5'h1F, 5'h02, 2'd2, 1'b1);
    tick(6);
    rst = 1'b1;
    expect_at(1, "rst_mid", 5'h00, 5'h00, 2'd0, 1'b0);
    tick(1);
    rst = 1'b0;
    expect_at(1, "post_rst_arm", 5'h00, 5'h00, 2'd1, 1'b0);
    expect_at(5, "post_rst_m1",  5'h00, 5'h00, 2'd1, 1'b0);
    expect_at(6, "post_rst",     5'h1F, 5'h1F, 2'd2, 1'b1);
    tick(6);

    tick(3);
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations never checked, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
